// File: rtl/fma_read_buffer.sv
// Streams a block of packed operand lines out of line-wide BRAM into the FMA bank.
// Reads are credit-limited against a small skid FIFO, so FMA backpressure never loses a line.
module fma_read_buffer #(
    parameter int unsigned FMA_COUNT    = 2,
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                start_in,
    input  logic [ADDR_WIDTH-1:0]               base_addr_in,
    input  logic [ADDR_WIDTH:0]                 line_count_in,
    output logic                                busy_out,
    output logic                                done_out,
    output logic [ADDR_WIDTH-1:0]               mem_addr_out,
    output logic                                mem_rd_en_out,
    input  logic [3*FMA_COUNT*WORD_WIDTH-1:0]   mem_line_in,
    output logic [FMA_COUNT*WORD_WIDTH-1:0]     fma_a_out,
    output logic [FMA_COUNT*WORD_WIDTH-1:0]     fma_b_out,
    output logic [FMA_COUNT*WORD_WIDTH-1:0]     fma_c_out,
    output logic                                fma_valid_out,
    input  logic                                fma_ready_in
);

    localparam int unsigned PHRASE_WIDTH = FMA_COUNT * WORD_WIDTH;
    localparam int unsigned LINE_WIDTH   = 3 * PHRASE_WIDTH;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic [ADDR_WIDTH:0]     issued_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rd_en_q;
    logic                    busy_q;
    logic                    done_q;

    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;

    logic [LINE_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        fifo_cnt_q;
    logic [CNT_W-1:0]        fifo_cnt_d;

    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    credit_ok;
    logic                    inflight_idle;
    logic [LINE_WIDTH-1:0]   head;
    int unsigned             outstanding;

    assign push          = pipe_q[READ_LATENCY-1];
    assign fifo_empty    = (fifo_cnt_q == '0);
    assign pop           = !fifo_empty && fma_ready_in;
    assign inflight_idle = !rd_en_q && (pipe_q == '0);
    assign issued_next   = issued_q + 1'b1;

    // Credit: every line not yet popped (FIFO, strobe on the bus, pipe) holds a FIFO slot.
    // Same-cycle pops are deliberately not counted so the push side never sees a full FIFO.
    always_comb begin
        outstanding = 32'(fifo_cnt_q) + 32'(rd_en_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding += 32'(pipe_q[i]);
        end
        credit_ok = (outstanding < FIFO_DEPTH);
    end

    // Read-valid shift register: the tail marks the cycle mem_line_in carries a requested line.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_en_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Next FIFO occupancy from simultaneous push/pop.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Control FSM with registered strobe, address, busy and done.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            base_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_in) begin
                        if (line_count_in != '0) begin
                            base_q   <= base_addr_in;
                            count_q  <= line_count_in;
                            issued_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= StIssue;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end
                    end
                end
                StIssue: begin
                    if (credit_ok) begin
                        rd_en_q  <= 1'b1;
                        // Line address wraps modulo the BRAM depth.
                        addr_q   <= base_q + issued_q[ADDR_WIDTH-1:0];
                        issued_q <= issued_next;
                        if (issued_next == count_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (inflight_idle && fifo_empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // In-flight pipe and FIFO pointers; reset discards anything still coming back from BRAM.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_line_in;
        end
    end

    assign head          = fifo_mem_q[rd_ptr_q];
    assign fma_valid_out = !fifo_empty;
    assign fma_a_out     = fifo_empty ? '0 : head[0*PHRASE_WIDTH +: PHRASE_WIDTH];
    assign fma_b_out     = fifo_empty ? '0 : head[1*PHRASE_WIDTH +: PHRASE_WIDTH];
    assign fma_c_out     = fifo_empty ? '0 : head[2*PHRASE_WIDTH +: PHRASE_WIDTH];

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign mem_addr_out  = addr_q;
    assign mem_rd_en_out = rd_en_q;

endmodule

// File: doc/fma_read_buffer.md
Name: fma_read_buffer

Overview:
Streams a contiguous block of packed operand lines out of line-wide BRAM and presents them to the FMA bank as per-FMA a/b/c operands.
It is the read-side counterpart of the FMA result write path and uses the same line layout: three phrases, each holding FMA_COUNT words.
An address generator issues reads, credit-limited against a small skid FIFO, so FMA backpressure never drops a line.

Parameters:
FMA_COUNT, 2, number of FMAs fed in lockstep per line
WORD_WIDTH, 16, bits per operand word
ADDR_WIDTH, 9, BRAM line-address width
READ_LATENCY, 2, cycles from mem_rd_en_out to valid mem_line_in (>=1)
FIFO_DEPTH, 4, line FIFO entries (power of 2, >= READ_LATENCY+2)
LINE_WIDTH (localparam), 3*FMA_COUNT*WORD_WIDTH, line width (96 by default)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous active-high reset
start_in  input  1  begin transfer; sampled only in IDLE
base_addr_in  input  ADDR_WIDTH  first line address, captured on accepted start
line_count_in  input  ADDR_WIDTH+1  number of lines to transfer, captured on accepted start
busy_out  output  1  high from accepted start until done
done_out  output  1  one-cycle pulse at transfer completion
mem_addr_out  output  ADDR_WIDTH  BRAM read address
mem_rd_en_out  output  1  BRAM read strobe
mem_line_in  input  LINE_WIDTH  BRAM read data
fma_a_out  output  FMA_COUNT*WORD_WIDTH  phrase 0; FMA i at bits [i*WORD_WIDTH +: WORD_WIDTH]
fma_b_out  output  FMA_COUNT*WORD_WIDTH  phrase 1, same packing
fma_c_out  output  FMA_COUNT*WORD_WIDTH  phrase 2, same packing
fma_valid_out  output  1  operand set valid for all FMAs
fma_ready_in  input  1  FMA bank accepts the operand set

Behaviour:
- Line layout: phrase p occupies bits [p*FMA_COUNT*WORD_WIDTH +: FMA_COUNT*WORD_WIDTH]; p=0→a, 1→b, 2→c.
- Reset (async, any time, including mid-transfer): state IDLE; FIFO, in-flight pipe and counters cleared; all outputs 0. In-flight BRAM data is discarded.
- FSM IDLE:
  - start_in=1 with line_count_in>0: capture base and count, go to ISSUE, busy_out=1.
  - start_in=1 with line_count_in=0: go to FINISH; no reads are issued.
- FSM ISSUE: each cycle, assert mem_rd_en_out (registered) if fifo_count + inflight_count < FIFO_DEPTH.
  - A pop in the same cycle does not add credit.
  - mem_addr_out = base + issued count, modulo 2^ADDR_WIDTH (wraps).
  - After the last read is issued, go to DRAIN.
- In-flight tracking: a READ_LATENCY-deep valid shift register. When its tail is set, mem_line_in is pushed into the FIFO on that edge. The credit rule guarantees the push never finds the FIFO full.
- Output:
  - fma_valid_out = !fifo_empty.
  - a/b/c outputs carry the FIFO head when valid and are 0 when empty.
  - Pop when fma_valid_out && fma_ready_in.
  - Valid/data hold stable while ready is low.
  - Lines are delivered in address order.
- FSM DRAIN: when nothing is in flight and the FIFO is empty after the last pop, go to FINISH.
- FSM FINISH: done_out=1 for one cycle, busy_out drops in the same cycle, then return to IDLE. A start_in asserted in FINISH is ignored.
- start_in while busy is ignored.
- Latency with start accepted at edge 0 and READ_LATENCY=2:
  - first mem_rd_en_out in cycle 1;
  - first fma_valid_out in cycle 1+READ_LATENCY+1 = 4.
  - With ready held high, throughput is one line per cycle.

Test Plan:
- Basic transfer: BRAM model returns line = {c=addr+200, b=addr+100, a=addr} per word; start with base=10, count=3, ready=1 → mem_addr_out 10,11,12 on consecutive cycles; fma_valid_out first high 4 cycles after start; a/b/c decode correctly; exactly one done_out pulse.
- Backpressure: count=8, ready=0 for 20 cycles, then 1 → at most 4 reads issued before the first pop; all 8 lines delivered in order with none lost or duplicated.
- Address wrap: base=511, count=3 → addresses 511, 0, 1.
- Zero count: start with count=0 → no mem_rd_en_out; done_out pulses one cycle after start; busy_out low after.
- Ready toggling every cycle, count=6 → one line per 2 cycles, order intact; start re-asserted mid-transfer has no effect.
- Reset mid-transfer after 2 lines delivered → all outputs 0 immediately; no further mem_rd_en_out. A new start (base=0, count=2) then completes normally.
